// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode constants
// for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam bit FWFT_OFF  = 1'b0;
  localparam bit FWFT_ON   = 1'b1;
  localparam int LVL_EXTRA = 1;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // level must hold DEPTH itself, hence one bit beyond the address
  function automatic int lvl_w(input int depth);
    return addr_w(depth) + LVL_EXTRA;
  endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// Simple dual-port storage: synchronous write,
// asynchronous read, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [addr_w(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [addr_w(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags,
// sticky error flags and optional first-word-fall-through.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = FWFT_OFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  input  logic                    clr_err,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = addr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign full         = count_q == FULL_L;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF_L;
  assign almost_empty = count_q <= AE_L;
  assign level        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // a fresh error in the clearing cycle must survive the clear
  always_comb begin
    ovf_d = ovf_q & ~clr_err;
    unf_d = unf_q & ~clr_err;
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end
    if (rd_en && empty) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  if (FWFT == FWFT_ON) begin : g_fwft
    assign rd_data  = mem_rdata;
    assign rd_valid = !empty;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q;

    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_ok) begin
        rd_data_d = mem_rdata;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_ok;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench: a standard-mode 32x32 FIFO
// and a FWFT 8x16 FIFO checked against queue models.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // ---------------- instance A: standard 32x32
  logic        a_rst = 1'b1, a_we = 1'b0;
  logic        a_re = 1'b0, a_clr = 1'b0;
  logic [31:0] a_wd = '0;
  logic [31:0] a_rd;
  logic        a_rv, a_full, a_empty, a_af, a_ae;
  logic        a_ovf, a_unf;
  logic [5:0]  a_lvl;

  sync_fifo_param u_a (
    .clk          (clk),
    .rst          (a_rst),
    .wr_en        (a_we),
    .wr_data      (a_wd),
    .rd_en        (a_re),
    .clr_err      (a_clr),
    .rd_data      (a_rd),
    .rd_valid     (a_rv),
    .full         (a_full),
    .empty        (a_empty),
    .almost_full  (a_af),
    .almost_empty (a_ae),
    .level        (a_lvl),
    .overflow     (a_ovf),
    .underflow    (a_unf)
  );

  // ---------------- instance B: FWFT 8x16
  logic        b_rst = 1'b1, b_we = 1'b0;
  logic        b_re = 1'b0, b_clr = 1'b0;
  logic [15:0] b_wd = '0;
  logic [15:0] b_rd;
  logic        b_rv, b_full, b_empty, b_af, b_ae;
  logic        b_ovf, b_unf;
  logic [3:0]  b_lvl;

  sync_fifo_param #(
    .WIDTH (16),
    .DEPTH (8),
    .FWFT  (1'b1)
  ) u_b (
    .clk          (clk),
    .rst          (b_rst),
    .wr_en        (b_we),
    .wr_data      (b_wd),
    .rd_en        (b_re),
    .clr_err      (b_clr),
    .rd_data      (b_rd),
    .rd_valid     (b_rv),
    .full         (b_full),
    .empty        (b_empty),
    .almost_full  (b_af),
    .almost_empty (b_ae),
    .level        (b_lvl),
    .overflow     (b_ovf),
    .underflow    (b_unf)
  );

  // ---------------- reference model A
  logic [31:0] qa [$];
  logic [31:0] sb [$];
  logic [31:0] a_hold;
  bit a_ov, a_un, a_v, a_arm;
  bit a_wa, a_ra;

  always @(posedge clk) begin
    if (a_rst) begin
      qa.delete();
      sb.delete();
      a_ov = 0; a_un = 0; a_v = 0;
      a_hold = '0;
      a_arm = 1;
    end else begin
      a_wa = a_we && qa.size() < 32;
      a_ra = a_re && qa.size() > 0;
      if (a_clr) begin
        a_ov = 0; a_un = 0;
      end
      if (a_we && qa.size() == 32) a_ov = 1;
      if (a_re && qa.size() == 0) a_un = 1;
      a_v = a_ra;
      if (a_ra) begin
        a_hold = qa.pop_front();
        sb.push_back(a_hold);
      end
      if (a_wa) qa.push_back(a_wd);
    end
  end

  always @(negedge clk) begin
    if (a_arm) begin
      int n;
      n = qa.size();
      chk("A.level", 64'(a_lvl), 64'(n));
      chk("A.full", 64'(a_full), 64'(n == 32));
      chk("A.empty", 64'(a_empty), 64'(n == 0));
      chk("A.afull", 64'(a_af), 64'(n >= 30));
      chk("A.aempty", 64'(a_ae), 64'(n <= 2));
      chk("A.ovf", 64'(a_ovf), 64'(a_ov));
      chk("A.unf", 64'(a_unf), 64'(a_un));
      chk("A.rd_valid", 64'(a_rv), 64'(a_v));
      if (a_rv) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL A.sb: got %0h expected none",
                   a_rd);
        end else begin
          chk("A.rd_data", 64'(a_rd), 64'(sb.pop_front()));
        end
      end else begin
        chk("A.rd_hold", 64'(a_rd), 64'(a_hold));
      end
    end
  end

  // ---------------- reference model B
  logic [15:0] qb [$];
  bit b_ov, b_un, b_arm;
  bit b_wa, b_ra;

  always @(posedge clk) begin
    if (b_rst) begin
      qb.delete();
      b_ov = 0; b_un = 0;
      b_arm = 1;
    end else begin
      b_wa = b_we && qb.size() < 8;
      b_ra = b_re && qb.size() > 0;
      if (b_clr) begin
        b_ov = 0; b_un = 0;
      end
      if (b_we && qb.size() == 8) b_ov = 1;
      if (b_re && qb.size() == 0) b_un = 1;
      if (b_ra) void'(qb.pop_front());
      if (b_wa) qb.push_back(b_wd);
    end
  end

  always @(negedge clk) begin
    if (b_arm) begin
      int n;
      n = qb.size();
      chk("B.level", 64'(b_lvl), 64'(n));
      chk("B.full", 64'(b_full), 64'(n == 8));
      chk("B.empty", 64'(b_empty), 64'(n == 0));
      chk("B.afull", 64'(b_af), 64'(n >= 6));
      chk("B.aempty", 64'(b_ae), 64'(n <= 2));
      chk("B.ovf", 64'(b_ovf), 64'(b_ov));
      chk("B.unf", 64'(b_unf), 64'(b_un));
      chk("B.rd_valid", 64'(b_rv), 64'(n != 0));
      if (n != 0) begin
        chk("B.rd_data", 64'(b_rd), 64'(qb[0]));
      end
    end
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sa(input bit we, input logic [31:0] wd,
                    input bit re, input bit clr);
    a_we = we; a_wd = wd; a_re = re; a_clr = clr;
    tick();
  endtask

  task automatic sbt(input bit we, input logic [15:0] wd,
                     input bit re, input bit clr);
    b_we = we; b_wd = wd; b_re = re; b_clr = clr;
    tick();
  endtask

  initial begin
    tick();
    tick();
    a_rst = 1'b0;
    b_rst = 1'b0;
    sa(0, 0, 0, 0);

    // fill, overflow, drain
    for (int i = 1; i <= 32; i++) sa(1, 32'(i), 0, 0);
    sa(1, 32'h21, 0, 0);
    for (int i = 0; i < 32; i++) sa(0, 0, 1, 0);
    sa(0, 0, 0, 0);

    // underflow then clear
    sa(0, 0, 1, 0);
    sa(0, 0, 0, 1);
    sa(0, 0, 0, 0);

    // steady level 5 with pointer wrap
    for (int i = 0; i < 5; i++) sa(1, $urandom, 0, 0);
    for (int i = 0; i < 200; i++) sa(1, $urandom, 1, 0);
    for (int i = 0; i < 5; i++) sa(0, 0, 1, 0);
    sa(0, 0, 0, 1);

    // write+read while full
    for (int i = 0; i < 32; i++) sa(1, $urandom, 0, 0);
    sa(1, 32'hAA, 1, 0);
    for (int i = 0; i < 32; i++) sa(0, 0, 1, 0);
    sa(0, 0, 0, 1);

    // reset at level 20 during a write
    for (int i = 0; i < 20; i++) sa(1, $urandom, 0, 0);
    a_rst = 1'b1;
    sa(1, 32'h5555, 0, 0);
    a_rst = 1'b0;
    sa(0, 0, 1, 0);
    sa(0, 0, 0, 0);

    // random traffic with occasional clear/reset
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = (i / 300) % 3;
      a_rst = ($urandom_range(0, 499) == 0);
      sa(ph == 2 ? $urandom_range(0, 3) == 0
                 : $urandom_range(0, 3) != 0,
         $urandom,
         ph == 0 ? $urandom_range(0, 3) == 0
                 : $urandom_range(0, 3) != 0,
         $urandom_range(0, 19) == 0);
    end
    a_rst = 1'b0;
    sa(0, 0, 0, 0);

    // FWFT: word visible without rd_en
    sbt(1, 16'hDEAD, 0, 0);
    sbt(0, 0, 0, 0);
    sbt(0, 0, 1, 0);
    sbt(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) sbt(1, 16'(i + 1), 0, 0);
    sbt(1, 16'h00AA, 1, 0);
    for (int i = 0; i < 9; i++) sbt(0, 0, 1, 0);
    sbt(0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      b_rst = ($urandom_range(0, 399) == 0);
      sbt($urandom_range(0, 1) == 1, 16'($urandom),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 15) == 0);
    end
    b_rst = 1'b0;
    sbt(0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
